mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RV32 pipeline: the consumer of the EX/MEM interface (`ctrl_mem`, `rd_mem`, `alu_result`, `write_data1`, `pc4_mem`). It performs word loads and stores through a variable-latency `req`/`ack` data-memory port, stalls the upstream stages while an access is outstanding, and registers the selected write-back value into the MEM/WB pipeline register. It enforces a bounded access time and flags misaligned or timed-out accesses.

## Interface
- `TIMEOUT`, default 16: number of `BUSY` cycles without `dmem_ack` before the access is abandoned (minimum 1).
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `ctrl_mem` input 5: [4] mem_read, [3] mem_write, [2] reg_write, [1:0] wb_sel (00 alu, 01 load data, 10 pc4, 11 alu).
- `rd_mem` input 32: destination register tag, passed through.
- `alu_result` input 32: memory address for loads/stores, or ALU write-back value.
- `write_data1` input 32: store data.
- `pc4_mem` input 32: PC+4 for link write-back.
- `stall` output 1: combinational; while high, upstream holds all EX/MEM inputs stable.
- `dmem_req` output 1: access request, registered.
- `dmem_we` output 1: 1 = store, 0 = load; valid while `dmem_req`.
- `dmem_addr` output 32: word address, registered, bits [1:0] always 0.
- `dmem_wdata` output 32: store data, registered.
- `dmem_rdata` input 32: load data, sampled in the `dmem_ack` cycle.
- `dmem_ack` input 1: single-cycle completion strobe; ignored outside `BUSY`.
- `ctrl_wb` output 3: {reg_write, wb_sel}.
- `rd_wb` output 32: registered destination tag.
- `wb_data` output 32: registered write-back value selected by wb_sel.
- `misaligned` output 1: one-cycle pulse, access with `alu_result[1:0]` ≠ 0.
- `bus_err` output 1: one-cycle pulse, access timed out.

## Operation
- FSM states: `IDLE`, `BUSY`.
- `IDLE`, no memory op (mem_read = mem_write = 0): MEM/WB loads `ctrl_wb = ctrl_mem[2:0]`, `rd_wb = rd_mem`, and `wb_data` = alu_result or pc4_mem per wb_sel. wb_sel = 01 with no load yields `alu_result`. `stall` = 0.
- `IDLE`, memory op, aligned: latch address/data/we, load `dmem_req` = 1, go to `BUSY`. `stall` = 1. MEM/WB loads a bubble (`ctrl_wb` = 0, `rd_wb` = 0, `wb_data` = 0).
- mem_read and mem_write both set: handled as a store (`dmem_we` = 1) with no load capture.
- `IDLE`, memory op, misaligned: no request issued. Pulse `misaligned`. MEM/WB loads `rd_wb`/`wb_data` as a non-memory op but with reg_write forced to 0. `stall` = 0.
- `BUSY`: `stall = ~dmem_ack` and the timeout counter increments each cycle.
  - On `dmem_ack`: drop `dmem_req` and return to `IDLE`. MEM/WB loads `ctrl_mem[2:0]` and `rd_mem`. `wb_data` = `dmem_rdata` for a load with wb_sel = 01; otherwise it follows the non-memory rule.
  - Timeout (counter = `TIMEOUT`-1 with no ack): drop `dmem_req`, pulse `bus_err`, write back with reg_write forced to 0, return to `IDLE`, and deassert `stall`.
- While in `BUSY` and not completing, MEM/WB holds a bubble.
- Ack in the same cycle as the timeout boundary: ack wins, no `bus_err`.
- Counter width: clog2(`TIMEOUT`)+1; it clears on every `IDLE` entry.

## Timing
- Reset (async assert): state `IDLE`, counter 0. All registered outputs are 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `ctrl_wb`, `rd_wb`, `wb_data`, `misaligned`, `bus_err`. Outputs go to 0 immediately, not at the next edge, including mid-access. A late `dmem_ack` after reset is ignored.
- Non-memory op: 1-cycle latency, input at edge N appears on MEM/WB outputs after edge N.
- Memory op: `dmem_req` rises after the accept edge. With ack in the first `BUSY` cycle, write-back appears after the ack edge, giving a minimum 2-cycle occupancy and 1 stall cycle.
- `stall` is valid combinationally within the cycle. Upstream must not change inputs while `stall` = 1.
- `misaligned` and `bus_err` are high for exactly one cycle, aligned with the MEM/WB update they qualify.

## Test plan
- Reset/pass-through: hold `reset` = 1, then release. Present ctrl = 5'b00100, alu_result = 32'h1234_5678, rd = 5 → after 1 edge: ctrl_wb = 3'b100, rd_wb = 5, wb_data = 32'h1234_5678, stall = 0.
- Load with 3-cycle ack delay: ctrl = 5'b10101, alu_result = 32'h0000_0100, dmem_rdata = 32'hDEAD_BEEF → dmem_req high 3 cycles, dmem_we = 0, dmem_addr = 32'h100, stall high 3 cycles, bubbles on MEM/WB, then wb_data = 32'hDEAD_BEEF with reg_write = 1.
- Store, immediate ack: ctrl = 5'b01000, alu_result = 32'h40, write_data1 = 32'hCAFE_F00D → one request cycle with dmem_we = 1 and dmem_wdata = 32'hCAFE_F00D, 1 stall cycle, ctrl_wb = 0.
- Misaligned: load with alu_result = 32'h102 → no dmem_req, misaligned pulses 1 cycle, reg_write = 0, stall stays 0.
- Timeout with `TIMEOUT` = 4 and no ack: dmem_req high exactly 4 cycles, then bus_err pulse, reg_write = 0, stall drops. Repeat with ack on the 4th cycle → no bus_err, load data written back.
- Reset mid-access: assert `reset` during BUSY → dmem_req and stall go to 0 without waiting for an edge. After release, a late ack is ignored and the next ALU op passes through normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32 pipeline.
// Consumes the EX/MEM register, performs word loads/stores over a
// variable-latency req/ack data port, stalls upstream while an access is
// outstanding, and registers the selected write-back value into MEM/WB.
// Misaligned accesses and accesses exceeding TIMEOUT busy cycles are flagged.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   ctrl_mem[4:0]              {mem_read, mem_write, reg_write, wb_sel[1:0]}
//   rd_mem, alu_result,        EX/MEM payload (dest tag, address/ALU value,
//   write_data1, pc4_mem         store data, link value)
//   stall                      combinational upstream hold
//   dmem_req/we/addr/wdata     registered data-memory request
//   dmem_rdata, dmem_ack       data-memory response
//   ctrl_wb, rd_wb, wb_data    registered MEM/WB payload
//   misaligned, bus_err        one-cycle error pulses aligned with MEM/WB
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ctrl_mem,
    input  logic [31:0] rd_mem,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data1,
    input  logic [31:0] pc4_mem,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [2:0]  ctrl_wb,
    output logic [31:0] rd_wb,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         ctrl_wb_q, ctrl_wb_d;
    logic [31:0]        rd_wb_q, rd_wb_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               mis_q, mis_d;
    logic               berr_q, berr_d;
    logic               stall_c;

    logic               mem_op;
    logic               aligned;
    logic               timeout_hit;
    logic [31:0]        plain_wb;

    // Decode of the EX/MEM payload shared by every state.
    always_comb begin
        mem_op      = ctrl_mem[4] | ctrl_mem[3];
        aligned     = (alu_result[1:0] == 2'b00);
        timeout_hit = (cnt_q == CNT_LAST);
        plain_wb    = (ctrl_mem[1:0] == 2'b10) ? pc4_mem : alu_result;
    end

    // Next-state and registered-output selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ctrl_wb_d = 3'b000;
        rd_wb_d   = 32'h0;
        wb_data_d = 32'h0;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        stall_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!mem_op) begin
                    ctrl_wb_d = ctrl_mem[2:0];
                    rd_wb_d   = rd_mem;
                    wb_data_d = plain_wb;
                end else if (!aligned) begin
                    mis_d     = 1'b1;
                    ctrl_wb_d = {1'b0, ctrl_mem[1:0]};
                    rd_wb_d   = rd_mem;
                    wb_data_d = plain_wb;
                end else begin
                    // Accept: MEM/WB gets a bubble while the request is issued.
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = ctrl_mem[3];
                    addr_d  = {alu_result[31:2], 2'b00};
                    wdata_d = write_data1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (dmem_ack) begin
                    // Ack takes priority over a coincident timeout.
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    ctrl_wb_d = ctrl_mem[2:0];
                    rd_wb_d   = rd_mem;
                    wb_data_d = (!we_q && ctrl_mem[1:0] == 2'b01) ? dmem_rdata : plain_wb;
                end else if (timeout_hit) begin
                    // Abandon the access; stall drops so upstream can advance.
                    req_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    berr_d    = 1'b1;
                    ctrl_wb_d = {1'b0, ctrl_mem[1:0]};
                    rd_wb_d   = rd_mem;
                    wb_data_d = plain_wb;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            ctrl_wb_q <= 3'b000;
            rd_wb_q   <= 32'h0;
            wb_data_q <= 32'h0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ctrl_wb_q <= ctrl_wb_d;
            rd_wb_q   <= rd_wb_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    // Stall is forced low while reset is held so upstream is released at once.
    assign stall      = stall_c & ~reset;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign ctrl_wb    = ctrl_wb_q;
    assign rd_wb      = rd_wb_q;
    assign wb_data    = wb_data_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage (TIMEOUT = 4). A transaction-
// level model predicts MEM/WB and request outputs; a negedge process compares
// them every cycle, and the directed sequence adds hand-computed checks.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  ctrl_mem = 5'b0;
    logic [31:0] rd_mem = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] write_data1 = 32'h0;
    logic [31:0] pc4_mem = 32'h0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic        stall, dmem_req, dmem_we, misaligned, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, rd_wb, wb_data;
    logic [2:0]  ctrl_wb;

    int n_checks = 0;
    int n_err    = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
        .alu_result(alu_result), .write_data1(write_data1), .pc4_mem(pc4_mem),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .wb_data(wb_data),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    logic        m_busy = 1'b0;
    int          m_wait = 0;
    logic        e_req = 1'b0, e_we = 1'b0, e_mis = 1'b0, e_berr = 1'b0;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_rd = 32'h0, e_wb = 32'h0;
    logic [2:0]  e_ctrl = 3'b0;

    function automatic logic [31:0] plain_value();
        return (ctrl_mem[1:0] == 2'b10) ? pc4_mem : alu_result;
    endfunction

    function automatic logic model_stall();
        if (reset) return 1'b0;
        if (!m_busy) return (ctrl_mem[4] | ctrl_mem[3]) && (alu_result[1:0] == 2'b00);
        return !dmem_ack && (m_wait != TO - 1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_wait <= 0; e_req <= 1'b0; e_we <= 1'b0;
            e_addr <= 32'h0; e_wdata <= 32'h0; e_rd <= 32'h0; e_wb <= 32'h0;
            e_ctrl <= 3'b0; e_mis <= 1'b0; e_berr <= 1'b0;
        end else begin
            e_mis <= 1'b0; e_berr <= 1'b0; e_ctrl <= 3'b0; e_rd <= 32'h0; e_wb <= 32'h0;
            if (!m_busy) begin
                if (!(ctrl_mem[4] | ctrl_mem[3])) begin
                    e_ctrl <= ctrl_mem[2:0]; e_rd <= rd_mem; e_wb <= plain_value();
                end else if (alu_result[1:0] != 2'b00) begin
                    e_mis <= 1'b1; e_ctrl <= {1'b0, ctrl_mem[1:0]};
                    e_rd <= rd_mem; e_wb <= plain_value();
                end else begin
                    m_busy <= 1'b1; m_wait <= 0; e_req <= 1'b1; e_we <= ctrl_mem[3];
                    e_addr <= alu_result; e_wdata <= write_data1;
                end
            end else if (dmem_ack) begin
                m_busy <= 1'b0; e_req <= 1'b0; e_ctrl <= ctrl_mem[2:0]; e_rd <= rd_mem;
                e_wb <= (ctrl_mem[4] && !ctrl_mem[3] && ctrl_mem[1:0] == 2'b01)
                        ? dmem_rdata : plain_value();
            end else if (m_wait == TO - 1) begin
                m_busy <= 1'b0; e_req <= 1'b0; e_berr <= 1'b1;
                e_ctrl <= {1'b0, ctrl_mem[1:0]}; e_rd <= rd_mem; e_wb <= plain_value();
            end else begin
                m_wait <= m_wait + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        check("stall", 32'(stall), 32'(model_stall()));
        check("dmem_req", 32'(dmem_req), 32'(e_req));
        if (e_req) begin
            check("dmem_we", 32'(dmem_we), 32'(e_we));
            check("dmem_addr", dmem_addr, e_addr);
            check("dmem_wdata", dmem_wdata, e_wdata);
        end
        check("ctrl_wb", 32'(ctrl_wb), 32'(e_ctrl));
        check("rd_wb", rd_wb, e_rd);
        check("wb_data", wb_data, e_wb);
        check("misaligned", 32'(misaligned), 32'(e_mis));
        check("bus_err", 32'(bus_err), 32'(e_berr));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        ctrl_mem = 5'b0; rd_mem = 32'h0; alu_result = 32'h0; write_data1 = 32'h0;
    endtask

    // Run one aligned access; ack_at = 0 means never ack (timeout path).
    task automatic access(input logic [4:0] ctrl, input logic [31:0] rd, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] rdata, input int ack_at,
                          input int exp_reqs, input int exp_stalls, input logic exp_berr,
                          input logic [31:0] exp_wb, input logic [2:0] exp_ctrl);
        int reqs;
        int stalls;
        int n;
        reqs = 0;
        stalls = 0;
        ctrl_mem = ctrl; rd_mem = rd; alu_result = alu; write_data1 = wd; dmem_rdata = rdata;
        n = (ack_at > 0) ? ack_at : TO;
        #1;
        if (stall) stalls++;
        tick();
        check("req_we", 32'(dmem_we), 32'(ctrl[3]));
        check("req_addr", dmem_addr, alu);
        check("req_wdata", dmem_wdata, wd);
        for (int i = 1; i <= n; i++) begin
            if (i == ack_at) dmem_ack = 1'b1;
            #1;
            if (dmem_req) reqs++;
            if (stall) stalls++;
            tick();
            dmem_ack = 1'b0;
        end
        check("req_cycles", 32'(reqs), 32'(exp_reqs));
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("done_bus_err", 32'(bus_err), 32'(exp_berr));
        check("done_wb_data", wb_data, exp_wb);
        check("done_ctrl_wb", 32'(ctrl_wb), 32'(exp_ctrl));
        check("done_rd_wb", rd_wb, rd);
        check("done_req_low", 32'(dmem_req), 32'h0);
        set_nop();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_wb", wb_data, 32'h0);
        reset = 1'b0;

        // Pass-through ALU op.
        ctrl_mem = 5'b00100; rd_mem = 32'd5; alu_result = 32'h1234_5678; pc4_mem = 32'h0000_2004;
        tick();
        check("pt_ctrl", 32'(ctrl_wb), 32'h4);
        check("pt_rd", rd_wb, 32'd5);
        check("pt_data", wb_data, 32'h1234_5678);
        check("pt_stall", 32'(stall), 32'h0);

        // Link write-back selects pc4; wb_sel=01 without a load selects alu.
        ctrl_mem = 5'b00110; rd_mem = 32'd1;
        tick();
        check("link_data", wb_data, 32'h0000_2004);
        ctrl_mem = 5'b00101; rd_mem = 32'd2;
        tick();
        check("sel01_data", wb_data, 32'h1234_5678);
        set_nop();
        tick();

        // Load, ack in third busy cycle.
        access(5'b10101, 32'd7, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3,
               3, 3, 1'b0, 32'hDEAD_BEEF, 3'b101);
        tick();
        // Store, immediate ack.
        access(5'b01000, 32'd8, 32'h0000_0040, 32'hCAFE_F00D, 32'h1111_1111, 1,
               1, 1, 1'b0, 32'h0000_0040, 3'b000);
        tick();
        // Read+write together behaves as a store, no load capture.
        access(5'b11101, 32'd6, 32'h0000_0300, 32'h0000_0077, 32'h9999_9999, 2,
               2, 2, 1'b0, 32'h0000_0300, 3'b101);
        tick();
        // Timeout: no ack.
        access(5'b10101, 32'd9, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 0,
               4, 4, 1'b1, 32'h0000_0200, 3'b001);
        check("berr_pulse_end", 32'(bus_err), 32'h1);
        tick();
        check("berr_one_cycle", 32'(bus_err), 32'h0);
        // Ack on the timeout boundary: ack wins.
        access(5'b10101, 32'd9, 32'h0000_0204, 32'h0, 32'h0BAD_F00D, TO,
               4, 4, 1'b0, 32'h0BAD_F00D, 3'b101);
        tick();

        // Misaligned load.
        ctrl_mem = 5'b10101; rd_mem = 32'd3; alu_result = 32'h0000_0102;
        #1;
        check("mis_stall", 32'(stall), 32'h0);
        tick();
        check("mis_pulse", 32'(misaligned), 32'h1);
        check("mis_ctrl", 32'(ctrl_wb), 32'h1);
        check("mis_data", wb_data, 32'h0000_0102);
        check("mis_rd", rd_wb, 32'd3);
        check("mis_noreq", 32'(dmem_req), 32'h0);
        set_nop();
        tick();
        check("mis_one_cycle", 32'(misaligned), 32'h0);

        // Reset in the middle of an access.
        ctrl_mem = 5'b10101; rd_mem = 32'd12; alu_result = 32'h0000_0400;
        tick();
        tick();
        check("mid_busy_req", 32'(dmem_req), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("async_req", 32'(dmem_req), 32'h0);
        check("async_stall", 32'(stall), 32'h0);
        check("async_ctrl", 32'(ctrl_wb), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ctrl_mem = 5'b00100; rd_mem = 32'd11; alu_result = 32'h0000_ABCD;
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("late_ack_data", wb_data, 32'h0000_ABCD);
        check("late_ack_ctrl", 32'(ctrl_wb), 32'h4);
        check("late_ack_rd", rd_wb, 32'd11);
        check("late_ack_req", 32'(dmem_req), 32'h0);
        check("late_ack_berr", 32'(bus_err), 32'h0);
        set_nop();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
